stepper_phase_driver: RTL and testbench

Consumes the 3-bit speed level produced by the key-driven speed FSM and turns it into coil phase drive for a 4-wire unipolar stepper. It synchronises and filters the speed code, which is generated off a key-derived edge and is not clk-synchronous. It then generates step timing from clk and sequences the coil pattern in full-step or half-step mode. It also tracks a wrap-around position count.

---
 rtl/stepper_phase_driver_if.sv | 20 ++
 rtl/stepper_phase_driver.sv | 151 +++++++++++++++
 tb/tb_stepper_phase_driver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stepper_phase_driver_if.sv
// Speed/run request in, coil drive and position status out, for the stepper phase driver.
interface stepper_phase_driver_if;
  logic [2:0]  speed_i;
  logic        enable_i;
  logic        dir_i;
  logic [3:0]  coils_o;
  logic        step_o;
  logic        running_o;
  logic [15:0] pos_o;

  modport master (
    output speed_i, enable_i, dir_i,
    input  coils_o, step_o, running_o, pos_o
  );

  modport slave (
    input  speed_i, enable_i, dir_i,
    output coils_o, step_o, running_o, pos_o
  );
endinterface

// File: rtl/stepper_phase_driver.sv
// Filters an asynchronous 3-bit speed code and sequences unipolar stepper coils at k*RATE_UNIT steps/s.
// Outputs are registered; a speed change takes effect only at the next step boundary.
module stepper_phase_driver #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int RATE_UNIT = 100,
  parameter int HALF_STEP = 0,
  parameter int HOLD      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stepper_phase_driver_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [31:0] P1 = 32'(CLK_HZ / (RATE_UNIT * 1));
  localparam logic [31:0] P2 = 32'(CLK_HZ / (RATE_UNIT * 2));
  localparam logic [31:0] P3 = 32'(CLK_HZ / (RATE_UNIT * 3));
  localparam logic [31:0] P4 = 32'(CLK_HZ / (RATE_UNIT * 4));
  localparam logic [31:0] P5 = 32'(CLK_HZ / (RATE_UNIT * 5));
  localparam logic [31:0] P6 = 32'(CLK_HZ / (RATE_UNIT * 6));

  logic [2:0]  s1_q, s2_q, s3_q;
  logic [2:0]  code_a_q, code_a_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  coils_q, coils_d;
  logic        step_q, step_d;
  logic [15:0] pos_q, pos_d;

  logic        valid;
  logic [31:0] period_sel;
  logic [2:0]  idx_raw;
  logic [2:0]  idx_next;

  function automatic logic [3:0] pattern(input logic [2:0] i);
    logic [3:0] p;
    if (HALF_STEP != 0) begin
      case (i)
        3'd0:    p = 4'b1000;
        3'd1:    p = 4'b1100;
        3'd2:    p = 4'b0100;
        3'd3:    p = 4'b0110;
        3'd4:    p = 4'b0010;
        3'd5:    p = 4'b0011;
        3'd6:    p = 4'b0001;
        default: p = 4'b1001;
      endcase
    end else begin
      case (i[1:0])
        2'd0:    p = 4'b1100;
        2'd1:    p = 4'b0110;
        2'd2:    p = 4'b0011;
        default: p = 4'b1001;
      endcase
    end
    return p;
  endfunction

  // A new code is accepted only after it has been seen on two consecutive synchroniser stages.
  always_comb begin
    code_a_d = code_a_q;
    if (s2_q == s3_q) code_a_d = s2_q;
  end

  assign valid = (code_a_q != 3'd0) && (code_a_q != 3'd7);

  always_comb begin
    case (code_a_q)
      3'd1:    period_sel = P1;
      3'd2:    period_sel = P2;
      3'd3:    period_sel = P3;
      3'd4:    period_sel = P4;
      3'd5:    period_sel = P5;
      3'd6:    period_sel = P6;
      default: period_sel = P1;
    endcase
  end

  assign idx_raw  = bus.dir_i ? (idx_q + 3'd1) : (idx_q - 3'd1);
  assign idx_next = (HALF_STEP != 0) ? idx_raw : {1'b0, idx_raw[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    coils_d = coils_q;
    step_d  = 1'b0;
    pos_d   = pos_q;
    case (state_q)
      IDLE: begin
        if (bus.enable_i && valid) begin
          state_d = RUN;
          cnt_d   = period_sel;
          coils_d = pattern(idx_q);
        end else if (HOLD == 0) begin
          coils_d = 4'b0000;
        end
      end
      default: begin
        // Stopping takes priority over a step due on the same edge.
        if (!bus.enable_i || !valid) begin
          state_d = IDLE;
          if (HOLD == 0) coils_d = 4'b0000;
        end else if (cnt_q == 32'd1) begin
          step_d  = 1'b1;
          idx_d   = idx_next;
          coils_d = pattern(idx_next);
          pos_d   = bus.dir_i ? (pos_q + 16'd1) : (pos_q - 16'd1);
          cnt_d   = period_sel;
        end else if (cnt_q > 32'd1) begin
          cnt_d = cnt_q - 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 3'd0;
      s2_q     <= 3'd0;
      s3_q     <= 3'd0;
      code_a_q <= 3'd0;
      state_q  <= IDLE;
      cnt_q    <= 32'd0;
      idx_q    <= 3'd0;
      coils_q  <= 4'b0000;
      step_q   <= 1'b0;
      pos_q    <= 16'd0;
    end else begin
      s1_q     <= bus.speed_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      code_a_q <= code_a_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      coils_q  <= coils_d;
      step_q   <= step_d;
      pos_q    <= pos_d;
    end
  end

  assign bus.coils_o   = coils_q;
  assign bus.step_o    = step_q;
  assign bus.running_o = (state_q == RUN);
  assign bus.pos_o     = pos_q;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Directed bench: three instances (full/hold, full/no-hold, half/hold) at CLK_HZ=1200, RATE_UNIT=10.
module tb_stepper_phase_driver;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  stepper_phase_driver_if if_a ();
  stepper_phase_driver_if if_b ();
  stepper_phase_driver_if if_c ();

  stepper_phase_driver #(.CLK_HZ(1200), .RATE_UNIT(10), .HALF_STEP(0), .HOLD(1))
    dut_a (.clk(clk), .rst_n(rst_n[0]), .bus(if_a));
  stepper_phase_driver #(.CLK_HZ(1200), .RATE_UNIT(10), .HALF_STEP(0), .HOLD(0))
    dut_b (.clk(clk), .rst_n(rst_n[1]), .bus(if_b));
  stepper_phase_driver #(.CLK_HZ(1200), .RATE_UNIT(10), .HALF_STEP(1), .HOLD(1))
    dut_c (.clk(clk), .rst_n(rst_n[2]), .bus(if_c));

  logic [2:0]  st_w;
  logic [2:0]  run_w;
  logic [3:0]  co_w [3];
  logic [15:0] ps_w [3];

  assign st_w[0] = if_a.step_o;    assign st_w[1] = if_b.step_o;    assign st_w[2] = if_c.step_o;
  assign run_w[0] = if_a.running_o; assign run_w[1] = if_b.running_o; assign run_w[2] = if_c.running_o;
  assign co_w[0] = if_a.coils_o;   assign co_w[1] = if_b.coils_o;   assign co_w[2] = if_c.coils_o;
  assign ps_w[0] = if_a.pos_o;     assign ps_w[1] = if_b.pos_o;     assign ps_w[2] = if_c.pos_o;

  logic [3:0] full_t [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
  logic [3:0] half_t [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                             4'b0010, 4'b0011, 4'b0001, 4'b1001};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic [2:0] spd, input logic en, input logic dr);
    case (d)
      0:       begin if_a.speed_i = spd; if_a.enable_i = en; if_a.dir_i = dr; end
      1:       begin if_b.speed_i = spd; if_b.enable_i = en; if_b.dir_i = dr; end
      default: begin if_c.speed_i = spd; if_c.enable_i = en; if_c.dir_i = dr; end
    endcase
  endtask

  task automatic set_speed(input int d, input logic [2:0] spd);
    case (d)
      0:       if_a.speed_i = spd;
      1:       if_b.speed_i = spd;
      default: if_c.speed_i = spd;
    endcase
  endtask

  task automatic set_en(input int d, input logic en);
    case (d)
      0:       if_a.enable_i = en;
      1:       if_b.enable_i = en;
      default: if_c.enable_i = en;
    endcase
  endtask

  // Cycles from now until the next step pulse; returns max when none arrives.
  task automatic wait_step(input int d, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!st_w[d] && n < max);
  endtask

  task automatic wait_run(input int d, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!run_w[d] && n < max);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++; if (co_w[d] !== 4'b0000) begin errors++; $display("FAIL reset_coils[%0d]: got %b want 0000", d, co_w[d]); end
      checks++; if (st_w[d] !== 1'b0) begin errors++; $display("FAIL reset_step[%0d]: got %b want 0", d, st_w[d]); end
      checks++; if (run_w[d] !== 1'b0) begin errors++; $display("FAIL reset_running[%0d]: got %b want 0", d, run_w[d]); end
      checks++; if (ps_w[d] !== 16'h0000) begin errors++; $display("FAIL reset_pos[%0d]: got %h want 0000", d, ps_w[d]); end
    end
  endtask

  task automatic test_startup();
    int n;
    set_in(0, 3'b001, 1'b1, 1'b1);
    tick();
    rst_n[0] = 1'b1;
    repeat (4) tick();
    checks++; if (run_w[0] !== 1'b0) begin errors++; $display("FAIL startup_run_edge4: got %b want 0", run_w[0]); end
    tick();
    checks++; if (run_w[0] !== 1'b1) begin errors++; $display("FAIL startup_run_edge5: got %b want 1", run_w[0]); end
    checks++; if (co_w[0] !== 4'b1100) begin errors++; $display("FAIL startup_coils: got %b want 1100", co_w[0]); end
    checks++; if (st_w[0] !== 1'b0) begin errors++; $display("FAIL startup_no_entry_step: got %b want 0", st_w[0]); end
    for (int i = 0; i < 4; i++) begin
      wait_step(0, 200, n);
      checks++; if (n !== 120) begin errors++; $display("FAIL startup_interval[%0d]: got %0d want 120", i, n); end
      checks++; if (co_w[0] !== full_t[(i + 1) % 4]) begin errors++; $display("FAIL startup_coils[%0d]: got %b want %b", i, co_w[0], full_t[(i + 1) % 4]); end
      checks++; if (ps_w[0] !== 16'(i + 1)) begin errors++; $display("FAIL startup_pos[%0d]: got %0d want %0d", i, ps_w[0], i + 1); end
    end
  endtask

  task automatic test_mid_change();
    int n;
    repeat (60) tick();
    set_speed(0, 3'b110);
    wait_step(0, 200, n);
    checks++; if (n !== 60) begin errors++; $display("FAIL midchg_old_period: got %0d want 60 (120 total)", n); end
    checks++; if (ps_w[0] !== 16'd5) begin errors++; $display("FAIL midchg_pos5: got %0d want 5", ps_w[0]); end
    for (int i = 0; i < 2; i++) begin
      wait_step(0, 200, n);
      checks++; if (n !== 20) begin errors++; $display("FAIL midchg_new_period[%0d]: got %0d want 20", i, n); end
    end
    checks++; if (ps_w[0] !== 16'd7) begin errors++; $display("FAIL midchg_pos7: got %0d want 7", ps_w[0]); end
    checks++; if (co_w[0] !== 4'b1001) begin errors++; $display("FAIL midchg_coils: got %b want 1001", co_w[0]); end
  endtask

  task automatic test_glitch();
    int n;
    set_speed(0, 3'b011);
    wait_step(0, 200, n);
    checks++; if (n !== 20) begin errors++; $display("FAIL glitch_tail_period: got %0d want 20", n); end
    wait_step(0, 200, n);
    checks++; if (n !== 40) begin errors++; $display("FAIL glitch_rate3: got %0d want 40", n); end
    tick();
    set_speed(0, 3'b111);
    tick();
    set_speed(0, 3'b011);
    wait_step(0, 200, n);
    checks++; if (n !== 38) begin errors++; $display("FAIL glitch_filtered: got %0d want 38 (40 total)", n); end
    wait_step(0, 200, n);
    checks++; if (n !== 40) begin errors++; $display("FAIL glitch_after: got %0d want 40", n); end
    tick();
    set_speed(0, 3'b111);
    repeat (4) tick();
    checks++; if (run_w[0] !== 1'b1) begin errors++; $display("FAIL stop111_edge4: got %b want 1", run_w[0]); end
    tick();
    checks++; if (run_w[0] !== 1'b0) begin errors++; $display("FAIL stop111_edge5: got %b want 0", run_w[0]); end
    checks++; if (ps_w[0] !== 16'd11) begin errors++; $display("FAIL stop111_pos: got %0d want 11", ps_w[0]); end
    checks++; if (co_w[0] !== 4'b1001) begin errors++; $display("FAIL stop111_hold: got %b want 1001", co_w[0]); end
  endtask

  // Stop lands on the counter==1 edge; hold_coils says whether the pattern is kept.
  task automatic test_stop_wins(input int d, input int start_pos, input bit hold_coils);
    int n;
    logic [3:0] c_run;
    set_in(d, 3'b010, 1'b1, 1'b1);
    wait_run(d, 20, n);
    checks++; if (run_w[d] !== 1'b1) begin errors++; $display("FAIL stop%0d_started: got %b want 1", d, run_w[d]); end
    wait_step(d, 200, n);
    c_run = full_t[(start_pos + 1) % 4];
    checks++; if (n !== 60) begin errors++; $display("FAIL stop%0d_first: got %0d want 60", d, n); end
    checks++; if (co_w[d] !== c_run) begin errors++; $display("FAIL stop%0d_coils: got %b want %b", d, co_w[d], c_run); end
    repeat (59) tick();
    set_en(d, 1'b0);
    tick();
    checks++; if (st_w[d] !== 1'b0) begin errors++; $display("FAIL stop%0d_nostep: got %b want 0", d, st_w[d]); end
    checks++; if (run_w[d] !== 1'b0) begin errors++; $display("FAIL stop%0d_running: got %b want 0", d, run_w[d]); end
    checks++; if (ps_w[d] !== 16'(start_pos + 1)) begin errors++; $display("FAIL stop%0d_pos: got %0d want %0d", d, ps_w[d], start_pos + 1); end
    checks++; if (co_w[d] !== (hold_coils ? c_run : 4'b0000)) begin errors++; $display("FAIL stop%0d_idle_coils: got %b want %b", d, co_w[d], hold_coils ? c_run : 4'b0000); end
    repeat (5) tick();
    set_en(d, 1'b1);
    tick();
    checks++; if (run_w[d] !== 1'b1) begin errors++; $display("FAIL stop%0d_reenter: got %b want 1", d, run_w[d]); end
    checks++; if (co_w[d] !== c_run) begin errors++; $display("FAIL stop%0d_reenter_coils: got %b want %b", d, co_w[d], c_run); end
    wait_step(d, 200, n);
    checks++; if (n !== 60) begin errors++; $display("FAIL stop%0d_restart_period: got %0d want 60", d, n); end
    checks++; if (ps_w[d] !== 16'(start_pos + 2)) begin errors++; $display("FAIL stop%0d_restart_pos: got %0d want %0d", d, ps_w[d], start_pos + 2); end
  endtask

  task automatic test_reverse();
    int n;
    rst_n[1] = 1'b0;
    set_in(1, 3'b010, 1'b1, 1'b0);
    tick();
    rst_n[1] = 1'b1;
    wait_run(1, 20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL rev_run_edge: got %0d want 5", n); end
    checks++; if (co_w[1] !== 4'b1100) begin errors++; $display("FAIL rev_entry_coils: got %b want 1100", co_w[1]); end
    wait_step(1, 200, n);
    checks++; if (n !== 60) begin errors++; $display("FAIL rev_first: got %0d want 60", n); end
    checks++; if (co_w[1] !== 4'b1001) begin errors++; $display("FAIL rev_coils1: got %b want 1001", co_w[1]); end
    checks++; if (ps_w[1] !== 16'hFFFF) begin errors++; $display("FAIL rev_pos1: got %h want ffff", ps_w[1]); end
    wait_step(1, 200, n);
    checks++; if (co_w[1] !== 4'b0011) begin errors++; $display("FAIL rev_coils2: got %b want 0011", co_w[1]); end
    checks++; if (ps_w[1] !== 16'hFFFE) begin errors++; $display("FAIL rev_pos2: got %h want fffe", ps_w[1]); end
  endtask

  task automatic test_half_and_reset();
    int n;
    set_in(2, 3'b110, 1'b1, 1'b1);
    tick();
    rst_n[2] = 1'b1;
    wait_run(2, 20, n);
    checks++; if (co_w[2] !== 4'b1000) begin errors++; $display("FAIL half_entry: got %b want 1000", co_w[2]); end
    for (int i = 0; i < 8; i++) begin
      wait_step(2, 100, n);
      checks++; if (n !== 20) begin errors++; $display("FAIL half_period[%0d]: got %0d want 20", i, n); end
      checks++; if (co_w[2] !== half_t[(i + 1) % 8]) begin errors++; $display("FAIL half_coils[%0d]: got %b want %b", i, co_w[2], half_t[(i + 1) % 8]); end
    end
    checks++; if (ps_w[2] !== 16'd8) begin errors++; $display("FAIL half_pos: got %0d want 8", ps_w[2]); end
    repeat (5) tick();
    #2;
    rst_n[2] = 1'b0;
    #1;
    checks++; if (co_w[2] !== 4'b0000) begin errors++; $display("FAIL arst_coils: got %b want 0000", co_w[2]); end
    checks++; if (ps_w[2] !== 16'd0) begin errors++; $display("FAIL arst_pos: got %0d want 0", ps_w[2]); end
    checks++; if (st_w[2] !== 1'b0) begin errors++; $display("FAIL arst_step: got %b want 0", st_w[2]); end
    checks++; if (run_w[2] !== 1'b0) begin errors++; $display("FAIL arst_running: got %b want 0", run_w[2]); end
  endtask

  initial begin
    rst_n = 3'b000;
    for (int d = 0; d < 3; d++) set_in(d, 3'b000, 1'b0, 1'b1);
    #3;
    test_reset();
    test_startup();
    test_mid_change();
    test_glitch();
    test_stop_wins(0, 11, 1'b1);
    rst_n[1] = 1'b1;
    test_stop_wins(1, 0, 1'b0);
    test_reverse();
    test_half_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
